event_dispatcher: RTL and testbench
===================================

// Module: event_dispatcher
// PURPOSE
//  Central PDES scheduler: pops the event-queue head and hands it to one idle core,
//  round-robin among requesting cores.
//  Owns the per-core busy flags and busy timestamps that feed the GVT min-tree, and
//  registers the returned GVT.
//  Enforces an optimistic time window above GVT and detects end of simulation.
// PARAMETERS
//  NUM_CORE  4       cores served; power of two, >=2
//  TIME_WID  16      timestamp width (unsigned)
//  DATA_WID  32      event payload width
//  WINDOW    64      max distance above GVT at which an event may be dispatched
//  END_TIME  16'hFFF0  events with time >= END_TIME are never dispatched
// PORTS
//  clk         in   1                    clock
//  rst         in   1                    synchronous, active-high reset
//  start       in   1                    level; begins scheduling from IDLE
//  q_vld       in   1                    event-queue head valid
//  q_time      in   TIME_WID             head timestamp
//  q_data      in   DATA_WID             head payload
//  q_deq       out  1                    one-cycle pop strobe to queue
//  core_req    in   NUM_CORE             core idle and asking for work
//  core_done   in   NUM_CORE             one-cycle pulse: core finished its event
//  disp_vld    out  NUM_CORE             one-hot dispatch strobe
//  disp_time   out  TIME_WID             dispatched timestamp, valid with disp_vld
//  disp_data   out  DATA_WID             dispatched payload, valid with disp_vld
//  core_times  out  TIME_WID*NUM_CORE    busy timestamp per core, core k at [k*TIME_WID +: TIME_WID]
//  core_vld    out  NUM_CORE             core busy flags, to GVT monitor
//  next_event  out  TIME_WID             q_time if q_vld else all-ones, to GVT monitor
//  gvt         in   TIME_WID             combinational GVT from monitor
//  gvt_reg     out  TIME_WID             registered, monotonic GVT
//  sim_done    out  1                    sticky termination flag
// BEHAVIOUR
//  Reset values: q_deq, disp_vld, core_vld, core_times, gvt_reg, disp_time and disp_data are 0.
//   sim_done is 0; FSM is IDLE; round-robin pointer is 0.
//  FSM
//   IDLE: go to RUN when start=1.
//   RUN: dispatch when eligible, then go to WAIT.
//   WAIT: hold exactly 1 cycle so the queue head can advance, then go to RUN.
//   DONE: absorbing; only rst leaves it.
//  Eligibility in RUN requires all of the following:
//   - q_vld=1
//   - q_time < END_TIME
//   - {1'b0,q_time} < {1'b0,gvt_reg}+WINDOW, computed at TIME_WID+1 bits so there is no wrap
//   - cand = core_req & ~core_vld is nonzero
//  Grant: round-robin over cand, starting at the pointer.
//   After a grant to core k, the pointer moves to (k+1) mod NUM_CORE.
//  Dispatch (registered; appears the cycle after the eligible RUN cycle):
//   - disp_vld[k]=1 and q_deq=1 for exactly 1 cycle
//   - disp_time and disp_data = q_time and q_data as sampled
//   - core_vld[k] <= 1 and core_times[k] <= q_time
//  Completion: core_done[k] with core_vld[k]=1 clears core_vld[k] next cycle.
//   core_done on an idle core is ignored.
//   core_req from a busy core is ignored.
//  Simultaneous events: core_done[k] and a grant in the same cycle cannot target the same core.
//   A busy core is never a candidate. A core freed this cycle is eligible from the next cycle.
//  GVT: gvt_reg <= gvt when gvt >= gvt_reg, otherwise it holds. GVT latency is 1 cycle.
//   Updates happen in every state except DONE.
//  Termination: in RUN or WAIT, go to DONE when both conditions hold for 2 consecutive cycles:
//   - (!q_vld || q_time >= END_TIME)
//   - core_vld == 0
//   In DONE, sim_done=1 and no further dispatch or deq occurs.
//  Window stall: the block stays in RUN with no outputs until GVT advances. No timeout.
//  Reset mid-operation: everything returns to reset values the next cycle.
//   In-flight cores are forgotten.
//  Per-core timestamps are not cleared on done; only core_vld gates them.
// STRUCTURE
//  pdes_pkg holds:
//   - TIME_WID, DATA_WID and NUM_CORE defaults
//   - TIME_MAX constant
//   - dispatcher state enum {IDLE, RUN, WAIT, DONE}
//  Sub-module rr_arbiter #(N): inputs req, advance; output one-hot grant; internal pointer.
//  next_event and the eligibility compare are combinational in the top level.
// TESTING
//  1. Reset, start, q_time=5, gvt=0, core_req=4'b0001.
//     -> disp_vld=0001, disp_time=5 and q_deq=1 exactly 2 cycles after start.
//     -> core_vld=0001, core_times[0]=5.
//  2. core_req=4'b1111 held, 4 events t=1,2,3,4.
//     -> grants go to cores 0,1,2,3 in order, each 2 cycles apart, no double dispatch.
//  3. gvt_reg=10, WINDOW=64, q_time=74: stall with no deq.
//     -> gvt=11 releases dispatch next RUN cycle.
//     -> gvt then drops to 9: gvt_reg holds at 11.
//  4. Core 2 busy; core_done[2] and core_req[2] in the same cycle.
//     -> no grant that cycle; core 2 granted the following eligible cycle.
//  5. Queue empties after the last dispatch; all core_done arrive.
//     -> sim_done=1 two cycles after core_vld==0; q_vld=1 afterwards causes no deq.
//  6. Assert rst in WAIT with core_vld=0011.
//     -> next cycle all outputs are 0 and state is IDLE; restart dispatches to core 0.

Source files
------------

// File: rtl/pdes_pkg.sv
// -----------------------------------------------------------------------------
// pdes_pkg
//   Shared definitions for the PDES scheduling slice.
//   - Default widths and core count used by event_dispatcher.
//   - TIME_MAX: the "no event" timestamp fed to the GVT min-tree.
//   - Dispatcher FSM state encoding.
// -----------------------------------------------------------------------------
package pdes_pkg;

  localparam int NUM_CORE_DEF = 4;
  localparam int TIME_WID_DEF = 16;
  localparam int DATA_WID_DEF = 32;

  // Largest representable timestamp. Any real event compares below it,
  // so the GVT min-tree ignores this value.
  localparam logic [TIME_WID_DEF-1:0] TIME_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } disp_state_e;

endpackage

// File: rtl/event_dispatcher_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with a registered priority pointer.
//   The search starts at the pointer and wraps. When advance_i is high and a
//   grant is produced, the pointer moves to the slot just after the winner, so
//   the winner becomes lowest priority next time.
// Ports
//   clk        clock
//   rst        synchronous active-high reset (pointer back to 0)
//   req_i      [N]  request vector
//   advance_i       commit the current grant and rotate the pointer
//   grant_o    [N]  one-hot grant (all zero when req_i is zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic [PW-1:0] gidx;
  logic          found;

  // N is a power of two, so adding in PW bits wraps modulo N for free.
  always_comb begin
    grant_o = '0;
    gidx    = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = ptr_q + PW'(i);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        gidx         = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = gidx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/event_dispatcher.sv
// -----------------------------------------------------------------------------
// event_dispatcher
//   Central PDES scheduler. Pops the event-queue head and hands it to one idle
//   core, round-robin among requesting cores. Tracks per-core busy flags and
//   busy timestamps for the GVT min-tree, registers the returned GVT (never
//   letting it go backwards), throttles dispatch to a window above GVT and
//   detects end of simulation.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         level; leaves IDLE
//   q_vld/q_time/q_data   event-queue head
//   q_deq         one-cycle pop strobe to the queue
//   core_req      per-core "idle, want work"
//   core_done     per-core one-cycle completion pulse
//   disp_vld      one-hot dispatch strobe
//   disp_time/disp_data   dispatched event, valid with disp_vld
//   core_times    busy timestamp per core, core k at [k*TIME_WID +: TIME_WID]
//   core_vld      per-core busy flags
//   next_event    head timestamp, or all-ones when the queue is empty
//   gvt           combinational GVT from the monitor
//   gvt_reg       registered monotonic GVT
//   sim_done      sticky end-of-simulation flag
// -----------------------------------------------------------------------------
module event_dispatcher
  import pdes_pkg::*;
#(
  parameter int                  NUM_CORE = NUM_CORE_DEF,
  parameter int                  TIME_WID = TIME_WID_DEF,
  parameter int                  DATA_WID = DATA_WID_DEF,
  parameter int                  WINDOW   = 64,
  parameter logic [TIME_WID-1:0] END_TIME = 16'hFFF0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         q_vld,
  input  logic [TIME_WID-1:0]          q_time,
  input  logic [DATA_WID-1:0]          q_data,
  output logic                         q_deq,
  input  logic [NUM_CORE-1:0]          core_req,
  input  logic [NUM_CORE-1:0]          core_done,
  output logic [NUM_CORE-1:0]          disp_vld,
  output logic [TIME_WID-1:0]          disp_time,
  output logic [DATA_WID-1:0]          disp_data,
  output logic [TIME_WID*NUM_CORE-1:0] core_times,
  output logic [NUM_CORE-1:0]          core_vld,
  output logic [TIME_WID-1:0]          next_event,
  input  logic [TIME_WID-1:0]          gvt,
  output logic [TIME_WID-1:0]          gvt_reg,
  output logic                         sim_done
);

  localparam logic [TIME_WID:0] WIN_EXT = (TIME_WID+1)'(WINDOW);

  disp_state_e                  state_q, state_d;
  logic                         term_q, term_d;
  logic [TIME_WID-1:0]          gvt_reg_q, gvt_reg_d;
  logic [NUM_CORE-1:0]          core_vld_q, core_vld_d;
  logic [TIME_WID*NUM_CORE-1:0] core_times_q, core_times_d;
  logic [NUM_CORE-1:0]          disp_vld_q, disp_vld_d;
  logic                         q_deq_q, q_deq_d;
  logic [TIME_WID-1:0]          disp_time_q, disp_time_d;
  logic [DATA_WID-1:0]          disp_data_q, disp_data_d;

  logic [NUM_CORE-1:0]          cand;
  logic [NUM_CORE-1:0]          grant;
  logic [NUM_CORE-1:0]          dispatch;
  logic                         below_end;
  logic                         in_window;
  logic                         eligible;
  logic                         term_cond;
  logic                         active;

  // Busy cores are excluded up front, so a core whose done pulse arrives
  // this cycle can only be picked once its busy flag has actually cleared.
  assign cand      = core_req & ~core_vld_q;
  assign below_end = (q_time < END_TIME);
  // One extra bit keeps gvt_reg + WINDOW from wrapping near TIME_MAX.
  assign in_window = ({1'b0, q_time} < ({1'b0, gvt_reg_q} + WIN_EXT));
  assign eligible  = (state_q == RUN) && q_vld && below_end && in_window && (|cand);
  assign dispatch  = eligible ? grant : '0;

  assign term_cond = (!q_vld || !below_end) && (core_vld_q == '0);
  assign active    = (state_q == RUN) || (state_q == WAIT);

  rr_arbiter #(
    .N(NUM_CORE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (cand),
    .advance_i (eligible),
    .grant_o   (grant)
  );

  // Control FSM. term_q remembers that the idle condition held last cycle;
  // seeing it again now makes two consecutive cycles and ends the run.
  always_comb begin
    state_d = state_q;
    term_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (eligible) state_d = WAIT;
      WAIT: state_d = RUN;
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (active) begin
      term_d = term_cond;
      if (term_cond && term_q) begin
        state_d = DONE;
      end
    end
  end

  // Datapath next-state: dispatch registers, busy tracking, GVT register.
  always_comb begin
    disp_vld_d   = dispatch;
    q_deq_d      = eligible;
    disp_time_d  = eligible ? q_time : disp_time_q;
    disp_data_d  = eligible ? q_data : disp_data_q;
    // A done pulse on an idle core clears an already-clear bit: harmless.
    core_vld_d   = (core_vld_q & ~core_done) | dispatch;
    // Timestamps are left stale on completion; core_vld gates their use.
    core_times_d = core_times_q;
    for (int k = 0; k < NUM_CORE; k++) begin
      if (dispatch[k]) begin
        core_times_d[k*TIME_WID +: TIME_WID] = q_time;
      end
    end
    gvt_reg_d = gvt_reg_q;
    if ((state_q != DONE) && (gvt >= gvt_reg_q)) begin
      gvt_reg_d = gvt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      term_q       <= 1'b0;
      gvt_reg_q    <= '0;
      core_vld_q   <= '0;
      core_times_q <= '0;
      disp_vld_q   <= '0;
      q_deq_q      <= 1'b0;
      disp_time_q  <= '0;
      disp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      term_q       <= term_d;
      gvt_reg_q    <= gvt_reg_d;
      core_vld_q   <= core_vld_d;
      core_times_q <= core_times_d;
      disp_vld_q   <= disp_vld_d;
      q_deq_q      <= q_deq_d;
      disp_time_q  <= disp_time_d;
      disp_data_q  <= disp_data_d;
    end
  end

  assign q_deq      = q_deq_q;
  assign disp_vld   = disp_vld_q;
  assign disp_time  = disp_time_q;
  assign disp_data  = disp_data_q;
  assign core_vld   = core_vld_q;
  assign core_times = core_times_q;
  assign gvt_reg    = gvt_reg_q;
  assign sim_done   = (state_q == DONE);
  assign next_event = q_vld ? q_time : '1;

endmodule

// File: tb/tb_event_dispatcher.sv
module tb_event_dispatcher;
  import pdes_pkg::*;

  localparam int NC = 4;
  localparam int TW = 16;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           q_vld;
  logic [TW-1:0]  q_time;
  logic [DW-1:0]  q_data;
  logic           q_deq;
  logic [NC-1:0]  core_req;
  logic [NC-1:0]  core_done;
  logic [NC-1:0]  disp_vld;
  logic [TW-1:0]  disp_time;
  logic [DW-1:0]  disp_data;
  logic [TW*NC-1:0] core_times;
  logic [NC-1:0]  core_vld;
  logic [TW-1:0]  next_event;
  logic [TW-1:0]  gvt;
  logic [TW-1:0]  gvt_reg;
  logic           sim_done;

  int total = 0;
  int bad   = 0;
  logic [TW-1:0] qt[$];

  event_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .q_vld      (q_vld),
    .q_time     (q_time),
    .q_data     (q_data),
    .q_deq      (q_deq),
    .core_req   (core_req),
    .core_done  (core_done),
    .disp_vld   (disp_vld),
    .disp_time  (disp_time),
    .disp_data  (disp_data),
    .core_times (core_times),
    .core_vld   (core_vld),
    .next_event (next_event),
    .gvt        (gvt),
    .gvt_reg    (gvt_reg),
    .sim_done   (sim_done)
  );

  always #5 clk = ~clk;

  task automatic refresh_q();
    if (qt.size() > 0) begin
      q_vld  = 1'b1;
      q_time = qt[0];
      q_data = {16'hDA7A, qt[0]};
    end else begin
      q_vld  = 1'b0;
      q_time = '0;
      q_data = '0;
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, then let the
  // queue model pop its head if the DUT strobed q_deq.
  task automatic tick();
    @(posedge clk);
    #1;
    if (q_deq === 1'b1 && qt.size() > 0) qt.delete(0);
    refresh_q();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    start     = 1'b0;
    core_req  = '0;
    core_done = '0;
    gvt       = '0;
    qt.delete();
    refresh_q();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    chk("rst_disp_vld",   64'(disp_vld),   64'h0);
    chk("rst_q_deq",      64'(q_deq),      64'h0);
    chk("rst_core_vld",   64'(core_vld),   64'h0);
    chk("rst_core_times", 64'(core_times), 64'h0);
    chk("rst_gvt_reg",    64'(gvt_reg),    64'h0);
    chk("rst_disp_time",  64'(disp_time),  64'h0);
    chk("rst_disp_data",  64'(disp_data),  64'h0);
    chk("rst_sim_done",   64'(sim_done),   64'h0);
    chk("rst_next_event", 64'(next_event), 64'(TIME_MAX));

    // ---------------- test 1: single dispatch, 2 cycles after start
    qt.push_back(16'd5);
    refresh_q();
    core_req = 4'b0001;
    start    = 1'b1;
    tick();
    chk("t1_no_disp_run", 64'(disp_vld), 64'h0);
    chk("t1_next_event",  64'(next_event), 64'd5);
    tick();
    chk("t1_disp_vld",   64'(disp_vld),   64'h1);
    chk("t1_q_deq",      64'(q_deq),      64'h1);
    chk("t1_disp_time",  64'(disp_time),  64'd5);
    chk("t1_disp_data",  64'(disp_data),  64'hDA7A0005);
    chk("t1_core_vld",   64'(core_vld),   64'h1);
    chk("t1_core_times", 64'(core_times), 64'h5);
    tick();
    chk("t1_deq_one_cycle", 64'(q_deq), 64'h0);

    // ---------------- test 2: round robin over 4 requesting cores
    do_reset();
    for (int t = 1; t <= 4; t++) qt.push_back(16'(t));
    refresh_q();
    core_req = 4'b1111;
    start    = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t2_grant%0d", k), 64'(disp_vld),  64'(1 << k));
      chk($sformatf("t2_time%0d", k),  64'(disp_time), 64'(k + 1));
      tick();
      chk($sformatf("t2_gap%0d", k),   64'(disp_vld),  64'h0);
    end
    chk("t2_core_vld",   64'(core_vld),   64'hF);
    chk("t2_core_times", 64'(core_times), 64'h0004_0003_0002_0001);

    // ---------------- test 3: window stall and monotonic GVT
    do_reset();
    gvt = 16'd10;
    tick();
    chk("t3_gvt10", 64'(gvt_reg), 64'd10);
    qt.push_back(16'd74);
    refresh_q();
    core_req = 4'b0001;
    start    = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_stall_deq%0d", i), 64'(q_deq),    64'h0);
      chk($sformatf("t3_stall_vld%0d", i), 64'(disp_vld), 64'h0);
    end
    gvt = 16'd11;
    tick();
    chk("t3_gvt11",       64'(gvt_reg),  64'd11);
    chk("t3_still_stall", 64'(disp_vld), 64'h0);
    tick();
    chk("t3_release_vld", 64'(disp_vld),  64'h1);
    chk("t3_release_deq", 64'(q_deq),     64'h1);
    chk("t3_release_t",   64'(disp_time), 64'd74);
    gvt = 16'd9;
    tick();
    chk("t3_gvt_hold", 64'(gvt_reg), 64'd11);

    // ---------------- test 4: done and req on same busy core, same cycle
    do_reset();
    qt.push_back(16'd20);
    qt.push_back(16'd21);
    refresh_q();
    core_req = 4'b0100;
    start    = 1'b1;
    tick();
    tick();
    chk("t4_first_grant", 64'(disp_vld), 64'h4);
    tick();
    chk("t4_busy_no_grant", 64'(disp_vld), 64'h0);
    core_done = 4'b0100;
    tick();
    core_done = 4'b0000;
    chk("t4_same_cycle_no_grant", 64'(disp_vld), 64'h0);
    chk("t4_core_freed",          64'(core_vld), 64'h0);
    tick();
    chk("t4_regrant",     64'(disp_vld),            64'h4);
    chk("t4_regrant_t",   64'(disp_time),           64'd21);
    chk("t4_core2_time",  64'(core_times[47:32]),   64'd21);

    // ---------------- test 5: termination
    core_done = 4'b0100;
    tick();
    core_done = 4'b0000;
    chk("t5_core_idle",  64'(core_vld), 64'h0);
    chk("t5_not_done0",  64'(sim_done), 64'h0);
    tick();
    chk("t5_not_done1",  64'(sim_done), 64'h0);
    tick();
    chk("t5_done",       64'(sim_done), 64'h1);
    qt.push_back(16'd30);
    refresh_q();
    core_req = 4'b1111;
    gvt      = 16'd500;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5_no_deq%0d", i), 64'(q_deq),    64'h0);
      chk($sformatf("t5_no_vld%0d", i), 64'(disp_vld), 64'h0);
      chk($sformatf("t5_sticky%0d", i), 64'(sim_done), 64'h1);
    end
    chk("t5_gvt_frozen", 64'(gvt_reg), 64'h0);

    // ---------------- test 6: reset in WAIT with two cores busy
    do_reset();
    gvt = 16'd5;
    qt.push_back(16'd1);
    qt.push_back(16'd2);
    qt.push_back(16'd3);
    refresh_q();
    core_req = 4'b0011;
    start    = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("t6_pre_core_vld", 64'(core_vld), 64'h3);
    chk("t6_pre_gvt",      64'(gvt_reg),  64'd5);
    rst = 1'b1;
    tick();
    chk("t6_rst_disp_vld",   64'(disp_vld),   64'h0);
    chk("t6_rst_q_deq",      64'(q_deq),      64'h0);
    chk("t6_rst_core_vld",   64'(core_vld),   64'h0);
    chk("t6_rst_core_times", 64'(core_times), 64'h0);
    chk("t6_rst_gvt_reg",    64'(gvt_reg),    64'h0);
    chk("t6_rst_disp_time",  64'(disp_time),  64'h0);
    chk("t6_rst_disp_data",  64'(disp_data),  64'h0);
    chk("t6_rst_sim_done",   64'(sim_done),   64'h0);
    rst   = 1'b0;
    start = 1'b0;
    qt.delete();
    qt.push_back(16'd7);
    refresh_q();
    tick();
    tick();
    chk("t6_idle_no_disp", 64'(disp_vld), 64'h0);
    start = 1'b1;
    tick();
    tick();
    chk("t6_restart_core0", 64'(disp_vld),  64'h1);
    chk("t6_restart_time",  64'(disp_time), 64'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
